// File: rtl/tick_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tick_ctrl_pkg
//
// Shared definitions for the tick controller slice:
//   - state_t         : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   - DIV_W_DEF       : default prescaler divide-value width
//   - DEB_CYCLES_DEF  : default debounce stable-sample count
//   - rise()          : rising-edge helper (current level vs. registered level)
//
// Optional build macro used by the consumers of this package: TICK_DEBOUNCE_EN
// -----------------------------------------------------------------------------
package tick_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int DIV_W_DEF      = 8;
   localparam int DEB_CYCLES_DEF = 16;

   // High for exactly the first cycle in which a level is seen high after
   // having been low on the previous cycle.
   function automatic logic rise(input logic cur, input logic prev);
      return cur & ~prev;
   endfunction

endpackage

// File: rtl/tick_ctrl_debounce.sv
// -----------------------------------------------------------------------------
// tick_debounce
//
// Two-flop synchronizer followed by a debouncer for one push-button level.
// The debounced output only changes after DEB_CYCLES consecutive synchronized
// samples that differ from the current output, so the delay from the first
// high sample of din to a changed dout is 2 + DEB_CYCLES cycles.
//
// Only instantiated by tick_ctrl when TICK_DEBOUNCE_EN is defined.
//
// Ports:
//   CLK    in   system clock, rising edge
//   RESET  in   asynchronous, active-high reset (clears all state)
//   din    in   raw asynchronous button level
//   dout   out  synchronized, debounced level
// -----------------------------------------------------------------------------
module tick_debounce
   import tick_ctrl_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic CLK,
   input  logic RESET,
   input  logic din,
   output logic dout
);

   localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          dout_q,  dout_d;
   logic [CW-1:0] cnt_q,   cnt_d;

   always_comb begin
      sync1_d = din;
      sync2_d = sync1_q;
      dout_d  = dout_q;
      cnt_d   = '0;
      // Count consecutive samples disagreeing with the output; any agreeing
      // sample restarts the run. The DEB_CYCLES-th disagreeing sample flips
      // the output.
      if (sync2_q != dout_q) begin
         if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            dout_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         dout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         dout_q  <= dout_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dout = dout_q;

endmodule

// File: rtl/tick_ctrl.sv
// -----------------------------------------------------------------------------
// tick_ctrl
//
// Start/stop controller with prescaler that generates count-enable pulses for
// a downstream 4-bit counter. While running, EN pulses once every DIV+1
// cycles. In one-shot mode (SINGLE=1) the controller halts in DONE after the
// downstream counter reports its carry.
//
// Build option:
//   TICK_DEBOUNCE_EN  defined   : START/STOP go through tick_debounce
//                                 (synchronizer + debouncer) before edge
//                                 detection, adding 2+DEB_CYCLES cycles.
//                     undefined : START/STOP feed the edge detector directly.
//
// Parameters:
//   DIV_W       width of DIV / prescaler counter
//   DEB_CYCLES  stable-sample count of the debouncer (debounce build only)
//
// Ports:
//   CLK     in   system clock, rising edge
//   RESET   in   asynchronous, active-high reset
//   START   in   start request level, rising edge = start event
//   STOP    in   stop request level, rising edge = stop event (beats START)
//   DIV     in   terminal count, sampled only at a start event
//   SINGLE  in   one-shot mode: go to DONE on CO_IN
//   CO_IN   in   carry-out of downstream counter (all ones AND EN)
//   EN      out  count-enable pulse, combinational from registered state
//   RUN     out  high while in RUN
//   DONE    out  high while in DONE
// -----------------------------------------------------------------------------
module tick_ctrl
   import tick_ctrl_pkg::*;
#(
   parameter int DIV_W      = DIV_W_DEF,
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic             STOP,
   input  logic [DIV_W-1:0] DIV,
   input  logic             SINGLE,
   input  logic             CO_IN,
   output logic             EN,
   output logic             RUN,
   output logic             DONE
);

   logic start_lvl;
   logic stop_lvl;

`ifdef TICK_DEBOUNCE_EN
   tick_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_deb_start (
      .CLK   (CLK),
      .RESET (RESET),
      .din   (START),
      .dout  (start_lvl)
   );

   tick_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_deb_stop (
      .CLK   (CLK),
      .RESET (RESET),
      .din   (STOP),
      .dout  (stop_lvl)
   );
`else
   // Without the debouncer the parameter has no consumer.
   logic unused_deb_cycles;
   assign unused_deb_cycles = (DEB_CYCLES != 0);

   assign start_lvl = START;
   assign stop_lvl  = STOP;
`endif

   state_t           state_q, state_d;
   logic [DIV_W-1:0] cnt_q,   cnt_d;
   logic [DIV_W-1:0] div_q,   div_d;
   logic             start_prev_q, start_prev_d;
   logic             stop_prev_q,  stop_prev_d;
   logic             run_q,   run_d;
   logic             done_q,  done_d;
   logic             start_evt;
   logic             stop_evt;
   logic             terminal;

   // cnt never exceeds div_q, so equality is the only wrap condition needed.
   assign terminal = (cnt_q == div_q);

   always_comb begin
      start_prev_d = start_lvl;
      stop_prev_d  = stop_lvl;
      start_evt    = rise(start_lvl, start_prev_q);
      stop_evt     = rise(stop_lvl,  stop_prev_q);

      state_d = state_q;
      cnt_d   = '0;
      div_d   = div_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            // A coincident stop event overrides the start event.
            if (stop_evt) begin
               state_d = ST_IDLE;
            end else if (start_evt) begin
               state_d = ST_RUN;
               div_d   = DIV;
            end
         end
         ST_RUN: begin
            if (stop_evt) begin
               state_d = ST_IDLE;
            end else if (SINGLE && CO_IN) begin
               state_d = ST_DONE;
            end else if (!terminal) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      run_d  = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         div_q        <= '0;
         start_prev_q <= 1'b0;
         stop_prev_q  <= 1'b0;
         run_q        <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         div_q        <= div_d;
         start_prev_q <= start_prev_d;
         stop_prev_q  <= stop_prev_d;
         run_q        <= run_d;
         done_q       <= done_d;
      end
   end

   // EN is built only from flops that RESET clears asynchronously, so it drops
   // the moment RESET rises, without waiting for a clock edge.
   assign EN   = run_q & terminal;
   assign RUN  = run_q;
   assign DONE = done_q;

endmodule

// File: tb/tb_tick_ctrl.sv
module tb_tick_ctrl;

`ifdef TICK_DEBOUNCE_EN
   localparam int DEB = 4;
   localparam int LAT = 2 + DEB;
`else
   localparam int DEB = 16;
   localparam int LAT = 0;
`endif

   logic       CLK = 1'b0;
   logic       RESET;
   logic       START;
   logic       STOP;
   logic [7:0] DIV;
   logic       SINGLE;
   logic       CO_IN;
   logic       EN;
   logic       RUN;
   logic       DONE;
   logic [3:0] q;

   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   // Downstream 4-bit counter.
   assign CO_IN = (q == 4'hF) & EN;
   always @(posedge CLK or posedge RESET) begin
      if (RESET) q <= 4'd0;
      else if (EN) q <= q + 4'd1;
   end

   tick_ctrl #(
      .DIV_W      (8),
      .DEB_CYCLES (DEB)
   ) dut (
      .CLK    (CLK),
      .RESET  (RESET),
      .START  (START),
      .STOP   (STOP),
      .DIV    (DIV),
      .SINGLE (SINGLE),
      .CO_IN  (CO_IN),
      .EN     (EN),
      .RUN    (RUN),
      .DONE   (DONE)
   );

   task automatic reset_dut();
      RESET = 1'b1;
      START = 1'b0;
      STOP  = 1'b0;
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
   endtask

   // Returns in the first cycle after the start event (cycle c1).
   task automatic start_pulse();
      START = 1'b1;
      repeat (LAT) @(negedge CLK);
      @(negedge CLK);
      START = 1'b0;
   endtask

   // Returns in the first cycle after the stop event.
   task automatic stop_pulse();
      STOP = 1'b1;
      repeat (LAT) @(negedge CLK);
      @(negedge CLK);
      STOP = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1; START = 1'b0; STOP = 1'b0; DIV = 8'd3; SINGLE = 1'b0;
      @(negedge CLK);
      checks++; if (EN !== 1'b0) begin failures++; $display("FAIL reset_en: EN=%b expected 0", EN); end
      checks++; if (RUN !== 1'b0) begin failures++; $display("FAIL reset_run: RUN=%b expected 0", RUN); end
      checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL reset_done: DONE=%b expected 0", DONE); end
      RESET = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         checks++;
         if ({EN, RUN, DONE} !== 3'b000) begin
            failures++; $display("FAIL post_reset c%0d: EN/RUN/DONE=%b expected 000", k, {EN, RUN, DONE});
         end
      end
   endtask

   task automatic test_div3();
      reset_dut();
      DIV = 8'd3; SINGLE = 1'b0;
      start_pulse();
      DIV = 8'd7;  // must be ignored until the next start
      for (int k = 1; k <= 12; k++) begin
         checks++;
         if (EN !== ((k % 4) == 0)) begin
            failures++; $display("FAIL div3_en c%0d: EN=%b expected %b", k, EN, ((k % 4) == 0));
         end
         checks++;
         if (RUN !== 1'b1) begin failures++; $display("FAIL div3_run c%0d: RUN=%b expected 1", k, RUN); end
         @(negedge CLK);
      end
      stop_pulse();
      checks++; if (RUN !== 1'b0) begin failures++; $display("FAIL stop_run: RUN=%b expected 0", RUN); end
      for (int k = 0; k < 4; k++) begin
         checks++; if (EN !== 1'b0) begin failures++; $display("FAIL stop_en c%0d: EN=%b expected 0", k, EN); end
         @(negedge CLK);
      end
   endtask

   task automatic test_div0();
      reset_dut();
      DIV = 8'd0; SINGLE = 1'b0;
      start_pulse();
      for (int k = 1; k <= 16; k++) begin
         checks++; if (EN !== 1'b1) begin failures++; $display("FAIL div0_en c%0d: EN=%b expected 1", k, EN); end
         checks++; if (q !== 4'(k - 1)) begin failures++; $display("FAIL div0_q c%0d: Q=%0d expected %0d", k, q, k - 1); end
         checks++; if (CO_IN !== (k == 16)) begin failures++; $display("FAIL div0_co c%0d: CO=%b expected %b", k, CO_IN, (k == 16)); end
         @(negedge CLK);
      end
      checks++; if (q !== 4'd0) begin failures++; $display("FAIL div0_wrap: Q=%0d expected 0", q); end
      checks++;
      if ({RUN, EN} !== 2'b11) begin failures++; $display("FAIL div0_free: RUN/EN=%b expected 11", {RUN, EN}); end
      stop_pulse();
   endtask

   task automatic test_single();
      int n;
      reset_dut();
      DIV = 8'd1; SINGLE = 1'b1;
      start_pulse();
      n = 0;
      for (int k = 1; k <= 40; k++) begin
         if (EN === 1'b1) n++;
         if (k == 32) begin
            checks++; if (CO_IN !== 1'b1) begin failures++; $display("FAIL single_co: CO=%b expected 1", CO_IN); end
         end
         if (k == 33) begin
            checks++; if (DONE !== 1'b1) begin failures++; $display("FAIL single_done_c33: DONE=%b expected 1", DONE); end
         end
         @(negedge CLK);
      end
      checks++; if (n != 16) begin failures++; $display("FAIL single_count: pulses=%0d expected 16", n); end
      checks++;
      if ({DONE, RUN, EN} !== 3'b100) begin failures++; $display("FAIL single_state: DONE/RUN/EN=%b expected 100", {DONE, RUN, EN}); end
      checks++; if (q !== 4'd0) begin failures++; $display("FAIL single_q: Q=%0d expected 0", q); end
      stop_pulse();
      checks++;
      if ({DONE, RUN} !== 2'b00) begin failures++; $display("FAIL done_stop: DONE/RUN=%b expected 00", {DONE, RUN}); end
      SINGLE = 1'b0;
   endtask

   task automatic test_start_stop_same();
      reset_dut();
      DIV = 8'd0;
      START = 1'b1; STOP = 1'b1;
      repeat (LAT + 1) @(negedge CLK);
      START = 1'b0; STOP = 1'b0;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if ({RUN, EN} !== 2'b00) begin failures++; $display("FAIL same_edge c%0d: RUN/EN=%b expected 00", k, {RUN, EN}); end
         @(negedge CLK);
      end
   endtask

   task automatic test_async_reset();
      reset_dut();
      DIV = 8'd0;
      start_pulse();
      @(negedge CLK);
      checks++; if (EN !== 1'b1) begin failures++; $display("FAIL areset_pre: EN=%b expected 1", EN); end
      #2 RESET = 1'b1;
      #1;
      checks++; if (EN !== 1'b0) begin failures++; $display("FAIL areset_en: EN=%b expected 0", EN); end
      checks++; if (RUN !== 1'b0) begin failures++; $display("FAIL areset_run: RUN=%b expected 0", RUN); end
      @(negedge CLK);
      RESET = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK);
         checks++;
         if ({RUN, EN} !== 2'b00) begin failures++; $display("FAIL areset_after c%0d: RUN/EN=%b expected 00", k, {RUN, EN}); end
      end
      start_pulse();
      checks++;
      if ({RUN, EN} !== 2'b11) begin failures++; $display("FAIL areset_restart: RUN/EN=%b expected 11", {RUN, EN}); end
      stop_pulse();
   endtask

`ifdef TICK_DEBOUNCE_EN
   task automatic test_debounce();
      reset_dut();
      DIV = 8'd0;
      START = 1'b1;
      repeat (2) @(negedge CLK);
      START = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         checks++; if (RUN !== 1'b0) begin failures++; $display("FAIL deb_glitch c%0d: RUN=%b expected 0", k, RUN); end
      end
      START = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge CLK);
         if (k == 6) begin
            checks++; if (RUN !== 1'b0) begin failures++; $display("FAIL deb_early: RUN=%b expected 0", RUN); end
         end
         if (k == 7) begin
            checks++; if (RUN !== 1'b1) begin failures++; $display("FAIL deb_run: RUN=%b expected 1", RUN); end
         end
      end
      START = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_div3();
      test_div0();
      test_single();
      test_start_stop_same();
      test_async_reset();
`ifdef TICK_DEBOUNCE_EN
      test_debounce();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
